// File: rtl/iob_rr_merge_pkg.sv
// Shared definitions for the round-robin native-bus merger:
// FSM encodings and derived bus widths.
package iob_rr_merge_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Request packs {valid,addr,wdata,wstrb}; response packs {rdata,ready}.
  function automatic int req_w(int aw, int dw);
    return 1 + aw + dw + dw / 8;
  endfunction

  function automatic int resp_w(int dw);
    return dw + 1;
  endfunction

  function automatic int grant_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iob_rr_merge_if.sv
// Bundle of the N master request/response buses, the single slave
// bus and the idle flag of the merger.
interface iob_rr_merge_if
  import iob_rr_merge_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);

  localparam int REQ_W  = req_w(ADDR_W, DATA_W);
  localparam int RESP_W = resp_w(DATA_W);

  logic [N_MASTERS*REQ_W-1:0]  m_req;
  logic [N_MASTERS*RESP_W-1:0] m_resp;
  logic [REQ_W-1:0]            s_req;
  logic [RESP_W-1:0]           s_resp;
  logic                        idle;

  // Environment side: drives master requests and slave responses.
  modport master (
    output m_req,
    output s_resp,
    input  m_resp,
    input  s_req,
    input  idle
  );

  // Merger side.
  modport slave (
    input  m_req,
    input  s_resp,
    output m_resp,
    output s_req,
    output idle
  );

endinterface

// File: rtl/rr_prio_enc.sv
// Round-robin priority encoder: first set request at or after
// rr_ptr, wrapping modulo N, via a double-width masked search.
module rr_prio_enc #(
  parameter int N       = 2,
  parameter int GRANT_W = 1
) (
  input  logic [N-1:0]       req,
  input  logic [GRANT_W-1:0] rr_ptr,
  output logic               any,
  output logic [GRANT_W-1:0] sel
);

  localparam int W2 = 2 * N;

  logic [W2-1:0] keep;
  logic [W2-1:0] dbl;
  logic          hit;

  // Lower copy drops bits below rr_ptr; upper copy supplies the wrap.
  always_comb begin
    keep = ~((W2'(1) << rr_ptr) - W2'(1));
    dbl  = {req, req} & keep;
    any  = |req;
    sel  = '0;
    hit  = 1'b0;
    for (int i = 0; i < W2; i++) begin
      if (!hit && dbl[i]) begin
        hit = 1'b1;
        sel = GRANT_W'(i % N);
      end
    end
  end

endmodule

// File: rtl/iob_rr_merge.sv
// Round-robin N:1 native-bus merger: one transaction at a time,
// fair arbitration, idle flag for the L2 invalidate interlock.
module iob_rr_merge
  import iob_rr_merge_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input logic          clk,
  input logic          rst,
  iob_rr_merge_if.slave bus
);

  localparam int REQ_W   = req_w(ADDR_W, DATA_W);
  localparam int RESP_W  = resp_w(DATA_W);
  localparam int GRANT_W = grant_w(N_MASTERS);

  logic [0:0]           state;
  logic [GRANT_W-1:0]   grant;
  logic [GRANT_W-1:0]   rr_ptr;
  logic [GRANT_W-1:0]   next_ptr;
  logic [GRANT_W-1:0]   req_sel;
  logic                 req_any;
  logic                 busy;
  logic                 s_ready;
  logic [DATA_W-1:0]    s_rdata;
  logic [N_MASTERS-1:0] m_valid;
  logic [REQ_W-1:0]     req_arr [N_MASTERS];
  logic [REQ_W-1:0]     gnt_req;

  assign busy    = (state == ST_BUSY);
  assign s_ready = bus.s_resp[0];
  assign s_rdata = bus.s_resp[RESP_W-1:1];

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_m
    assign req_arr[i] = bus.m_req[i*REQ_W +: REQ_W];
    assign m_valid[i] = req_arr[i][REQ_W-1];
    assign bus.m_resp[i*RESP_W +: RESP_W] =
      (busy && grant == GRANT_W'(i) && s_ready)
        ? {s_rdata, 1'b1} : '0;
  end

  rr_prio_enc #(
    .N       (N_MASTERS),
    .GRANT_W (GRANT_W)
  ) u_enc (
    .req    (m_valid),
    .rr_ptr (rr_ptr),
    .any    (req_any),
    .sel    (req_sel)
  );

  assign gnt_req  = req_arr[grant];
  assign next_ptr = (grant == GRANT_W'(N_MASTERS - 1))
                  ? '0 : grant + GRANT_W'(1);

  // Slave sees nothing while idle, so a stray request never leaks.
  assign bus.s_req = busy ? gnt_req : '0;
  assign bus.idle  = !busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (req_any) begin
            grant <= req_sel;
            state <= ST_BUSY;
          end
        end
        (state == ST_BUSY): begin
          if (s_ready) begin
            rr_ptr <= next_ptr;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A granted master must hold valid until it is answered.
  a_hold_valid: assert property (
    @(posedge clk) disable iff (rst)
    busy |-> gnt_req[REQ_W-1]
  );

endmodule
